// File: rtl/decoder_pipe_if.sv
// Handshake/bus bundle for decoder_pipe: request side (in_*) and result side (out*).
interface decoder_pipe_if #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 2**IN_WIDTH
);
   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_sel;
   logic                 in_en;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out;
   logic                 out_err;

   modport master (
      output in_valid, in_sel, in_en, out_ready,
      input  in_ready, out_valid, out, out_err
   );

   modport slave (
      input  in_valid, in_sel, in_en, out_ready,
      output in_ready, out_valid, out, out_err
   );
endinterface

// File: rtl/decoder_pipe.sv
// Registered flow-controlled binary-to-one-hot decoder with a 2-entry skid buffer.
// Optional stats counters enabled by defining DECODER_PIPE_STATS_EN.
module decoder_pipe #(
   parameter int IN_WIDTH   = 8,
   parameter int OUT_WIDTH  = 2**IN_WIDTH,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic clk,
   input  logic rst,
   decoder_pipe_if.slave bus
`ifdef DECODER_PIPE_STATS_EN
   ,
   output logic [15:0] stat_xfer,
   output logic [15:0] stat_err
`endif
);

   localparam logic [OUT_WIDTH-1:0] IDLE = {OUT_WIDTH{ACTIVE_LOW}};

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t               state, state_next;
   logic                 in_xfer, out_xfer;
   logic                 load_from_in, load_from_skid, load_skid;
   logic                 in_ready_q, out_valid_q, err_q;
   logic [OUT_WIDTH-1:0] out_q;
   logic [IN_WIDTH-1:0]  skid_sel;
   logic                 skid_en;
   logic [IN_WIDTH-1:0]  dec_sel;
   logic                 dec_en;
   logic [OUT_WIDTH-1:0] dec_word;
   logic                 dec_err;

   assign in_xfer  = bus.in_valid & in_ready_q;
   assign out_xfer = out_valid_q & bus.out_ready;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.out_err   = err_q;

   // Handshake flags are registered copies of the next state, not decodes of it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state       <= state_next;
         out_valid_q <= (state_next != EMPTY);
         in_ready_q  <= (state_next != FULL);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY: if (in_xfer) state_next = ONE;
         ONE: begin
            case ({in_xfer, out_xfer})
               2'b01:   state_next = EMPTY;
               2'b10:   state_next = FULL;
               default: state_next = ONE;
            endcase
         end
         FULL:    if (out_xfer) state_next = ONE;
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      load_from_in   = in_xfer && ((state == EMPTY) || (state == ONE && out_xfer));
      load_skid      = in_xfer && (state == ONE) && !out_xfer;
      load_from_skid = (state == FULL) && out_xfer;
      dec_sel        = load_from_skid ? skid_sel : bus.in_sel;
      dec_en         = load_from_skid ? skid_en  : bus.in_en;
   end

   always_comb begin
      dec_word = IDLE;
      dec_err  = 1'b0;
      if (dec_en) begin
         if (32'(dec_sel) >= OUT_WIDTH) dec_err = 1'b1;
         for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
            if (32'(dec_sel) == i) dec_word[i] = ~IDLE[i];
         end
      end
   end

   // The skid keeps the raw request; decoding happens once, on the way into out_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q    <= IDLE;
         err_q    <= 1'b0;
         skid_sel <= '0;
         skid_en  <= 1'b0;
      end else begin
         if (load_from_in || load_from_skid) begin
            out_q <= dec_word;
            err_q <= dec_err;
         end
         if (load_skid) begin
            skid_sel <= bus.in_sel;
            skid_en  <= bus.in_en;
         end
      end
   end

`ifdef DECODER_PIPE_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_xfer <= '0;
         stat_err  <= '0;
      end else if (out_xfer) begin
         if (stat_xfer != '1) stat_xfer <= stat_xfer + 16'd1;
         if (err_q && stat_err != '1) stat_err <= stat_err + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed self-checking bench for decoder_pipe over three configurations.
module tb_decoder_pipe;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   decoder_pipe_if #(.IN_WIDTH(8), .OUT_WIDTH(256)) ia ();
   decoder_pipe_if #(.IN_WIDTH(8), .OUT_WIDTH(200)) ir ();
   decoder_pipe_if #(.IN_WIDTH(3), .OUT_WIDTH(8))   il ();

`ifdef DECODER_PIPE_STATS_EN
   logic [15:0] sx_a, se_a, sx_r, se_r, sx_l, se_l;
`endif

   decoder_pipe #(.IN_WIDTH(8), .OUT_WIDTH(256), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst(rst), .bus(ia.slave)
`ifdef DECODER_PIPE_STATS_EN
      , .stat_xfer(sx_a), .stat_err(se_a)
`endif
   );

   decoder_pipe #(.IN_WIDTH(8), .OUT_WIDTH(200), .ACTIVE_LOW(1'b0)) dut_r (
      .clk(clk), .rst(rst), .bus(ir.slave)
`ifdef DECODER_PIPE_STATS_EN
      , .stat_xfer(sx_r), .stat_err(se_r)
`endif
   );

   decoder_pipe #(.IN_WIDTH(3), .OUT_WIDTH(8), .ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst(rst), .bus(il.slave)
`ifdef DECODER_PIPE_STATS_EN
      , .stat_xfer(sx_l), .stat_err(se_l)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", ia.out_valid); end
      checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ia.in_ready); end
      checks++; if (ia.out !== 256'd0) begin failures++; $display("FAIL reset_out: got %h expected 0", ia.out); end
      checks++; if (ia.out_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", ia.out_err); end
      checks++; if (il.out !== 8'hFF) begin failures++; $display("FAIL reset_out_low: got %h expected ff", il.out); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_walk();
      logic [255:0] e;
      ia.out_ready = 1'b1;
      ia.in_valid  = 1'b1;
      ia.in_en     = 1'b1;
      ia.in_sel    = 8'd0;
      step();
      e = 256'd1;
      checks++; if (ia.out_valid !== 1'b1 || ia.out !== e) begin failures++; $display("FAIL walk_0: got v=%b %h expected v=1 %h", ia.out_valid, ia.out, e); end
      checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL walk_ready0: got %b expected 1", ia.in_ready); end
      ia.in_sel = 8'd1;
      step();
      e = 256'd2;
      checks++; if (ia.out_valid !== 1'b1 || ia.out !== e) begin failures++; $display("FAIL walk_1: got v=%b %h expected v=1 %h", ia.out_valid, ia.out, e); end
      ia.in_sel = 8'd255;
      step();
      e = 256'd1 << 255;
      checks++; if (ia.out_valid !== 1'b1 || ia.out !== e) begin failures++; $display("FAIL walk_255: got v=%b %h expected v=1 %h", ia.out_valid, ia.out, e); end
      checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL walk_ready2: got %b expected 1", ia.in_ready); end
      ia.in_valid = 1'b0;
      step();
      checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL walk_drain: got %b expected 0", ia.out_valid); end
   endtask

   task automatic test_backpressure();
      ia.out_ready = 1'b0;
      ia.in_valid  = 1'b1;
      ia.in_en     = 1'b1;
      ia.in_sel    = 8'd3;
      step();
      checks++; if (ia.out !== (256'd1 << 3) || ia.in_ready !== 1'b1) begin failures++; $display("FAIL bp_first: got out=%h rdy=%b expected out=8 rdy=1", ia.out, ia.in_ready); end
      ia.in_sel = 8'd7;
      step();
      checks++; if (ia.out !== (256'd1 << 3) || ia.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full: got out=%h rdy=%b expected out=8 rdy=0", ia.out, ia.in_ready); end
      ia.in_valid = 1'b0;
      ia.in_sel   = 8'd99;
      step();
      checks++; if (ia.out !== (256'd1 << 3) || ia.out_valid !== 1'b1 || ia.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold: got out=%h v=%b rdy=%b expected out=8 v=1 rdy=0", ia.out, ia.out_valid, ia.in_ready); end
      ia.out_ready = 1'b1;
      step();
      checks++; if (ia.out !== (256'd1 << 7) || ia.out_valid !== 1'b1 || ia.in_ready !== 1'b1) begin failures++; $display("FAIL bp_second: got out=%h v=%b rdy=%b expected out=80 v=1 rdy=1", ia.out, ia.out_valid, ia.in_ready); end
      step();
      checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b expected 0", ia.out_valid); end
   endtask

   task automatic test_range();
      logic [199:0] e;
      ir.out_ready = 1'b1;
      ir.in_valid  = 1'b1;
      ir.in_en     = 1'b1;
      ir.in_sel    = 8'd200;
      step();
      checks++; if (ir.out !== 200'd0 || ir.out_err !== 1'b1 || ir.out_valid !== 1'b1) begin failures++; $display("FAIL range_200: got out=%h err=%b v=%b expected out=0 err=1 v=1", ir.out, ir.out_err, ir.out_valid); end
      ir.in_sel = 8'd199;
      step();
      e = 200'd1 << 199;
      checks++; if (ir.out !== e || ir.out_err !== 1'b0) begin failures++; $display("FAIL range_199: got out=%h err=%b expected out=%h err=0", ir.out, ir.out_err, e); end
      ir.in_en  = 1'b0;
      ir.in_sel = 8'd5;
      step();
      checks++; if (ir.out !== 200'd0 || ir.out_err !== 1'b0 || ir.out_valid !== 1'b1) begin failures++; $display("FAIL range_dis: got out=%h err=%b v=%b expected out=0 err=0 v=1", ir.out, ir.out_err, ir.out_valid); end
      ir.in_valid = 1'b0;
      step();
   endtask

   task automatic test_active_low();
      il.out_ready = 1'b1;
      il.in_valid  = 1'b1;
      il.in_en     = 1'b1;
      il.in_sel    = 3'd2;
      step();
      checks++; if (il.out !== 8'b1111_1011) begin failures++; $display("FAIL low_2: got %b expected 11111011", il.out); end
      il.in_sel = 3'd7;
      step();
      checks++; if (il.out !== 8'b0111_1111 || il.out_err !== 1'b0) begin failures++; $display("FAIL low_7: got %b err=%b expected 01111111 err=0", il.out, il.out_err); end
      il.in_valid = 1'b0;
      step();
   endtask

   task automatic test_mid_reset();
      ia.out_ready = 1'b0;
      ia.in_valid  = 1'b1;
      ia.in_en     = 1'b1;
      ia.in_sel    = 8'd10;
      step();
      ia.in_sel = 8'd20;
      step();
      ia.in_valid = 1'b0;
      checks++; if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b1) begin failures++; $display("FAIL mr_full: got rdy=%b v=%b expected rdy=0 v=1", ia.in_ready, ia.out_valid); end
      rst = 1'b0;
      #1;
      checks++; if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1 || ia.out !== 256'd0) begin failures++; $display("FAIL mr_async: got v=%b rdy=%b out=%h expected v=0 rdy=1 out=0", ia.out_valid, ia.in_ready, ia.out); end
      checks++; if (il.out !== 8'hFF) begin failures++; $display("FAIL mr_low_idle: got %h expected ff", il.out); end
      step();
      rst = 1'b1;
      ia.out_ready = 1'b1;
      step();
      step();
      checks++; if (ia.out_valid !== 1'b0 || ia.out !== 256'd0 || ia.in_ready !== 1'b1) begin failures++; $display("FAIL mr_stale: got v=%b out=%h rdy=%b expected v=0 out=0 rdy=1", ia.out_valid, ia.out, ia.in_ready); end
   endtask

`ifdef DECODER_PIPE_STATS_EN
   task automatic test_stats();
      ir.out_ready = 1'b1;
      ir.in_valid  = 1'b1;
      ir.in_en     = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ir.in_sel = (i == 4) ? 8'd250 : 8'(i);
         step();
      end
      ir.in_valid = 1'b0;
      step();
      checks++; if (sx_r !== 16'd10 || se_r !== 16'd1) begin failures++; $display("FAIL stats_10: got xfer=%0d err=%0d expected xfer=10 err=1", sx_r, se_r); end
      ir.in_valid = 1'b1;
      for (int i = 0; i < 69990; i++) begin
         ir.in_sel = (i == 100 || i == 30000) ? 8'd210 : 8'(i % 200);
         step();
      end
      ir.in_valid = 1'b0;
      step();
      checks++; if (sx_r !== 16'hFFFF) begin failures++; $display("FAIL stats_sat: got %h expected ffff", sx_r); end
      checks++; if (se_r !== 16'd3) begin failures++; $display("FAIL stats_err: got %0d expected 3", se_r); end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      ia.in_valid = 1'b0; ia.in_sel = '0; ia.in_en = 1'b0; ia.out_ready = 1'b0;
      ir.in_valid = 1'b0; ir.in_sel = '0; ir.in_en = 1'b0; ir.out_ready = 1'b0;
      il.in_valid = 1'b0; il.in_sel = '0; il.in_en = 1'b0; il.out_ready = 1'b0;
      test_reset();
      test_walk();
      test_backpressure();
      test_range();
      test_active_low();
      test_mid_reset();
`ifdef DECODER_PIPE_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
